shift_deserializer: RTL and testbench
=====================================

// Module: shift_deserializer
// PURPOSE
//  Serial-in/parallel-out receiver: far end of the shift-right serial link.
//  Rebuilds WIDTH-bit words from a bit stream strobed by bit_en, framed by start.
//  Presents each word on a valid/ready output with a one-word holding register.
//  Sits between the serial link pins and the parallel consumer (LEDR/HEX logic).
// PARAMETERS
//  WIDTH      8  bits per word (>=2)
//  MSB_FIRST  0  0: first received bit -> data_out[0]; 1: first bit -> data_out[WIDTH-1]
// PORTS
//  clk        in   1      clock, rising edge
//  reset_n    in   1      asynchronous reset, active low
//  start      in   1      frame start pulse (1 cycle); aborts any partial word
//  bit_en     in   1      serial bit strobe; ser_in sampled when high
//  ser_in     in   1      serial data
//  out_ready  in   1      consumer accepts data_out when high with out_valid
//  data_out   out  WIDTH  last completed word
//  out_valid  out  1      data_out holds an unaccepted word
//  busy       out  1      frame in progress (state RECV)
//  overrun    out  1      1-cycle pulse: completed word dropped
// BEHAVIOUR
//  Reset (async, reset_n=0): state IDLE, bit counter 0, shift reg 0, data_out 0,
//   out_valid 0, busy 0, overrun 0. Takes effect immediately, mid-frame included.
//  States: IDLE, RECV. busy = (state==RECV), registered.
//  IDLE: start=1 -> RECV, count=0, shift reg cleared. bit_en ignored in IDLE
//   and in the start cycle.
//  RECV, start=1: restart (count=0, shift reg cleared, stay RECV); bit_en that
//   cycle ignored. start has priority over bit_en.
//  RECV, bit_en=1, start=0: sample ser_in.
//   MSB_FIRST=0: sr <= {ser_in, sr[WIDTH-1:1]}; MSB_FIRST=1: sr <= {sr[WIDTH-2:0], ser_in}.
//   count < WIDTH-1: count++.
//   count == WIDTH-1 (word complete): -> IDLE, count=0, completed word = new sr value.
//  RECV, bit_en=0: hold; no timeout.
//  Output handshake (evaluated every cycle, completion C, accept A=out_valid&out_ready):
//   C & (~out_valid | A): data_out <= word, out_valid <= 1 (visible cycle after
//    the WIDTH-th bit_en edge; latency 1 clock).
//   C & out_valid & ~A: word dropped, data_out unchanged, out_valid stays 1,
//    overrun=1 for one cycle.
//   ~C & A: out_valid <= 0; data_out keeps old value.
//  data_out changes only on load; stable while out_valid & ~out_ready.
//  Counter width $clog2(WIDTH); never exceeds WIDTH-1 (no wrap in normal flow).
//  No partial word is ever presented on data_out.
// TESTING
//  1 reset_n=0 async mid-frame -> data_out=0, out_valid=0, busy=0 same cycle, no clk needed.
//  2 MSB_FIRST=0, start then bits 1,0,1,0,0,1,0,1 on bit_en -> data_out=8'hA5,
//    out_valid=1 one cycle after 8th bit_en, busy=0.
//  3 out_ready=0 holding 8'hA5; second frame of 8'h3C completes -> overrun 1-cycle
//    pulse, data_out stays 8'hA5; then out_ready=1 -> out_valid=0 next cycle.
//  4 start, 3 bits, start again, 8 bits of 8'h0F LSB-first -> data_out=8'h0F only
//    (no word from the aborted 3 bits).
//  5 completion in same cycle as out_ready=1 with 8'hA5 pending, new word 8'h5A ->
//    data_out=8'h5A, out_valid stays 1, overrun=0.
//  6 MSB_FIRST=1, bits 0,0,0,1,0,0,1,0 with gaps between bit_en -> data_out=8'h12.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver: rebuilds WIDTH-bit words from a bit_en-strobed stream framed by start.
// Latency: completed word appears on data_out/out_valid one clock after the WIDTH-th sampled bit.
// Backpressure: one-word holding register; a word completing while an unaccepted word is held is dropped (overrun pulse).
module shift_deserializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             bit_en,
   input  logic             ser_in,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t           state;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_shift;
   logic             complete;
   logic             accept;

   // Shift-register value after sampling ser_in, in the configured bit order
   generate
      if (MSB_FIRST) begin : g_msb
         assign sr_shift = {sr[WIDTH-2:0], ser_in};
      end else begin : g_lsb
         assign sr_shift = {ser_in, sr[WIDTH-1:1]};
      end
   endgenerate

   // A word completes on the last bit of a frame; start aborts and wins over bit_en
   assign complete = (state == RECV) && bit_en && !start && (count == LAST);
   assign accept   = out_valid && out_ready;

   // Frame FSM: start (re)opens a frame, bit_en shifts bits in, the last bit closes it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         count <= '0;
         sr    <= '0;
         busy  <= 1'b0;
      end else if (start) begin
         state <= RECV;
         count <= '0;
         sr    <= '0;
         busy  <= 1'b1;
      end else if ((state == RECV) && bit_en) begin
         sr <= sr_shift;
         if (count == LAST) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   // Holding register: load when empty or being drained, otherwise drop and flag overrun
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (complete) begin
            if (!out_valid || accept) begin
               data_out  <= sr_shift;
               out_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: two instances (LSB-first and MSB-first) share one stimulus stream.
// A queue-based frame model predicts both outputs every cycle; directed cases pin known words.
// Random phase exercises restarts, gaps, backpressure, overruns and async resets.
module tb_shift_deserializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic         bit_en = 1'b0;
   logic         ser_in = 1'b0;
   logic         out_ready = 1'b0;

   logic [W-1:0] d0, d1;
   logic         v0, v1, b0, b1, o0, o1;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .start(start), .bit_en(bit_en), .ser_in(ser_in),
      .out_ready(out_ready), .data_out(d0), .out_valid(v0), .busy(b0), .overrun(o0));

   shift_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start), .bit_en(bit_en), .ser_in(ser_in),
      .out_ready(out_ready), .data_out(d1), .out_valid(v1), .busy(b1), .overrun(o1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           m_q[$];
   bit           m_inf   = 1'b0;
   bit           m_valid = 1'b0;
   bit           m_ovr   = 1'b0;
   logic [W-1:0] m_d0    = '0;
   logic [W-1:0] m_d1    = '0;
   logic [W-1:0] w0, w1;
   bit           comp, acc;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q.delete();
         m_inf   = 1'b0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
         m_d0    = '0;
         m_d1    = '0;
      end else begin
         comp  = 1'b0;
         m_ovr = 1'b0;
         w0    = '0;
         w1    = '0;
         if (start) begin
            m_inf = 1'b1;
            m_q.delete();
         end else if (m_inf && bit_en) begin
            m_q.push_back(ser_in);
            if (m_q.size() == W) begin
               comp = 1'b1;
               foreach (m_q[i]) begin
                  w0[i]       = m_q[i];
                  w1[W-1-i]   = m_q[i];
               end
               m_q.delete();
               m_inf = 1'b0;
            end
         end
         acc = m_valid && out_ready;
         if (comp && (!m_valid || acc)) begin
            m_d0    = w0;
            m_d1    = w1;
            m_valid = 1'b1;
         end else if (comp) begin
            m_ovr = 1'b1;
         end else if (acc) begin
            m_valid = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("data_lsb",  32'(d0), 32'(m_d0));
         chk("data_msb",  32'(d1), 32'(m_d1));
         chk("valid_lsb", 32'(v0), 32'(m_valid));
         chk("valid_msb", 32'(v1), 32'(m_valid));
         chk("busy_lsb",  32'(b0), 32'(m_inf));
         chk("busy_msb",  32'(b1), 32'(m_inf));
         chk("ovr_lsb",   32'(o0), 32'(m_ovr));
         chk("ovr_msb",   32'(o1), 32'(m_ovr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input logic s, input logic b, input logic d, input logic r);
      start     = s;
      bit_en    = b;
      ser_in    = d;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   // w[i] is the i-th bit sent; ready r during the frame, r_last on the final bit
   task automatic frame(input logic [W-1:0] w, input logic r, input logic r_last, input int gap);
      cyc(1'b1, 1'b0, 1'b0, r);
      for (int i = 0; i < W; i++) begin
         repeat (gap) cyc(1'b0, 1'b0, $urandom_range(0, 1), r);
         cyc(1'b0, 1'b1, w[i], (i == W - 1) ? r_last : r);
      end
   endtask

   task automatic async_reset();
      #1 reset_n = 1'b0;
      #1;
      chk("rst_data",  32'(d0), 32'h0);
      chk("rst_valid", 32'(v0), 32'h0);
      chk("rst_busy",  32'(b0), 32'h0);
      chk("rst_msb",   32'({d1, v1, b1, o1}), 32'h0);
      #1 reset_n = 1'b1;
      start  = 1'b0;
      bit_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("init_state", 32'({d0, v0, b0, o0}), 32'h0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cmp_en = 1'b1;

      // Mid-frame async reset with a word held
      frame(8'h77, 1'b0, 1'b0, 0);
      chk("pre_rst_word", 32'(d0), 32'h77);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("pre_rst_busy", 32'(b0), 32'h1);
      async_reset();

      // LSB-first A5
      frame(8'hA5, 1'b0, 1'b0, 0);
      chk("a5_data",  32'(d0), 32'hA5);
      chk("a5_valid", 32'(v0), 32'h1);
      chk("a5_busy",  32'(b0), 32'h0);

      // Second word while A5 is held -> dropped
      frame(8'h3C, 1'b0, 1'b0, 0);
      chk("ovr_pulse", 32'(o0), 32'h1);
      chk("ovr_keep",  32'(d0), 32'hA5);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovr_1cyc",  32'(o0), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("drain_valid", 32'(v0), 32'h0);
      chk("drain_data",  32'(d0), 32'hA5);

      // Aborted partial frame then 0F
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk("abort_novalid", 32'(v0), 32'h0);
      frame(8'h0F, 1'b0, 1'b0, 0);
      chk("abort_lsb", 32'(d0), 32'h0F);
      chk("abort_msb", 32'(d1), 32'hF0);

      // Completion in the same cycle the pending A5 is accepted
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      frame(8'hA5, 1'b0, 1'b0, 0);
      frame(8'h5A, 1'b0, 1'b1, 0);
      chk("same_data",  32'(d0), 32'h5A);
      chk("same_valid", 32'(v0), 32'h1);
      chk("same_ovr",   32'(o0), 32'h0);

      // MSB-first 0,0,0,1,0,0,1,0 with gaps
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      frame(8'h48, 1'b0, 1'b0, 2);
      chk("msb_data", 32'(d1), 32'h12);
      chk("msb_lsbview", 32'(d0), 32'h48);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            async_reset();
         end else begin
            cyc($urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 1), $urandom_range(0, 2) == 0);
         end
      end

      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
